// File: rtl/mili_stim_gen_pkg.sv
// rtl/mili_stim_gen_pkg.sv - shared encodings for the stimulus generator and the 4-state detector
package mili_stim_gen_pkg;

    localparam int LEN_W  = 5;
    localparam int RATE_W = 4;

    typedef enum logic [1:0] {
        CTL_IDLE = 2'd0,
        CTL_RUN  = 2'd1,
        CTL_FIN  = 2'd2
    } ctl_state_e;

    typedef enum logic [1:0] {
        DET_S0 = 2'd0,
        DET_S1 = 2'd1,
        DET_S2 = 2'd2,
        DET_S3 = 2'd3
    } det_state_e;

    function automatic det_state_e det_next(input det_state_e s, input logic a);
        det_state_e n;
        unique case (s)
            DET_S0:  n = a ? DET_S0 : DET_S1;
            DET_S1:  n = a ? DET_S1 : DET_S2;
            DET_S2:  n = a ? DET_S0 : DET_S3;
            default: n = a ? DET_S2 : DET_S0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mili_stim_gen_if.sv
// rtl/mili_stim_gen_if.sv - control, stimulus and detector-feedback bundle of the stimulus generator
interface mili_stim_gen_if #(
    parameter int PAT_W = 16,
    parameter int CNT_W = 8
);
    logic                                 start;
    logic                                 abort;
    logic [PAT_W-1:0]                     pattern;
    logic [mili_stim_gen_pkg::LEN_W-1:0]  len;
    logic [mili_stim_gen_pkg::RATE_W-1:0] rate;
    logic                                 y_in;
    logic                                 a_out;
    logic                                 en_out;
    logic                                 det_clr_n;
    logic                                 busy;
    logic                                 done;
    logic [CNT_W-1:0]                     hit_cnt;
    logic                                 mismatch;
    mili_stim_gen_pkg::det_state_e        det_state;

    modport master (
        output start, abort, pattern, len, rate, y_in,
        input  a_out, en_out, det_clr_n, busy, done, hit_cnt, mismatch, det_state
    );

    modport slave (
        input  start, abort, pattern, len, rate, y_in,
        output a_out, en_out, det_clr_n, busy, done, hit_cnt, mismatch, det_state
    );
endinterface

// File: rtl/mili_ref_model.sv
// rtl/mili_ref_model.sv - cycle-exact copy of the driven 4-state detector used for prediction
module mili_ref_model
    import mili_stim_gen_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       a,
    output det_state_e state,
    output logic       y
);
    det_state_e state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DET_S0;
        end else if (clr) begin
            state_q <= DET_S0;
        end else if (en) begin
            state_q <= det_next(state_q, a);
        end
    end

    assign state = state_q;
    assign y     = a && (state_q == DET_S1);

endmodule

// File: rtl/mili_stim_gen.sv
// rtl/mili_stim_gen.sv - serial pattern driver for the 4-state detector with hit prediction and checking
module mili_stim_gen
    import mili_stim_gen_pkg::*;
#(
    parameter int PAT_W = 16,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mili_stim_gen_if.slave  bus
);
    localparam logic [LEN_W-1:0] PAT_LEN = LEN_W'(PAT_W);

    ctl_state_e        state_q, state_d;
    logic [RATE_W-1:0] div_q, div_d;
    logic [RATE_W-1:0] rate_q, rate_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [CNT_W-1:0]  hit_q, hit_d;
    logic              mis_q, mis_d;

    logic              accept;
    logic              strobe;
    logic              a_bit;
    logic              y_pred;
    logic [LEN_W-1:0]  len_eff;
    det_state_e        model_state;

    // Pattern is stored left-aligned so the next bit to send is always the MSB.
    assign a_bit = (state_q == CTL_RUN) ? pat_q[PAT_W-1] : 1'b0;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        rate_d  = rate_q;
        rem_d   = rem_q;
        pat_d   = pat_q;
        hit_d   = hit_q;
        mis_d   = mis_q;
        accept  = 1'b0;
        strobe  = 1'b0;
        len_eff = (bus.len > PAT_LEN) ? PAT_LEN : bus.len;

        unique case (state_q)
            CTL_IDLE: begin
                if (bus.start && !bus.abort && (bus.len != '0)) begin
                    accept  = 1'b1;
                    state_d = CTL_RUN;
                    div_d   = '0;
                    rate_d  = bus.rate;
                    rem_d   = len_eff;
                    pat_d   = bus.pattern << (PAT_LEN - len_eff);
                    hit_d   = '0;
                    mis_d   = 1'b0;
                end
            end
            CTL_RUN: begin
                if (bus.abort) begin
                    state_d = CTL_IDLE;
                end else if (div_q == rate_q) begin
                    strobe = 1'b1;
                    div_d  = '0;
                    pat_d  = pat_q << 1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = CTL_FIN;
                    end
                    if (y_pred && (hit_q != '1)) begin
                        hit_d = hit_q + 1'b1;
                    end
                    if (bus.y_in != y_pred) begin
                        mis_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            CTL_FIN: begin
                state_d = CTL_IDLE;
            end
            default: begin
                state_d = CTL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CTL_IDLE;
            div_q   <= '0;
            rate_q  <= '0;
            rem_q   <= '0;
            pat_q   <= '0;
            hit_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            rate_q  <= rate_d;
            rem_q   <= rem_d;
            pat_q   <= pat_d;
            hit_q   <= hit_d;
            mis_q   <= mis_d;
        end
    end

    mili_ref_model u_model (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (strobe),
        .a     (a_bit),
        .state (model_state),
        .y     (y_pred)
    );

    assign bus.a_out     = a_bit;
    assign bus.en_out    = strobe;
    assign bus.det_clr_n = !accept;
    assign bus.busy      = (state_q == CTL_RUN);
    assign bus.done      = (state_q == CTL_FIN);
    assign bus.hit_cnt   = hit_q;
    assign bus.mismatch  = mis_q;
    assign bus.det_state = model_state;

endmodule
